pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the multi-cycle core; successor to the fixed 12-bit PC.
- Runs NUM_PROGS programs, each with a run-time-programmable start/end address pair; a start pulse launches the selected program.
- Relative branch offsets come from a run-time-writable lookup table instead of fixed init data.
- Owns the per-instruction phase counter internally and emits a one-cycle halt pulse at program end.

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_sequencer_branch_lut.sv | 32 +++
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_seq_pkg;

  localparam int DEF_PC_W      = 12;
  localparam int DEF_LUT_DEPTH = 32;
  localparam int DEF_OFFSET_W  = 9;
  localparam int DEF_NUM_PROGS = 3;
  localparam int DEF_CPI       = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

  // Branch offset entry at the default offset width: dir=1 means backward.
  typedef struct packed {
    logic                    dir;
    logic [DEF_OFFSET_W-1:0] mag;
  } br_off_t;

endpackage

// File: rtl/pc_sequencer_branch_lut.sv
// Branch-offset register file: one synchronous write port, one combinational
// read port; a same-cycle write/read of one index returns the old entry.
module branch_lut
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = DEF_LUT_DEPTH,
  parameter int DW    = DEF_OFFSET_W + 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem_reg [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        mem_reg[gi] <= '0;
      end else if (we && waddr == ($clog2(DEPTH))'(gi)) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer with programmable slots and branch LUT.
// Optional absolute branch path enabled by defining PC_SEQUENCER_BRANCH_ABS_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int LUT_DEPTH = DEF_LUT_DEPTH,
  parameter int OFFSET_W  = DEF_OFFSET_W,
  parameter int NUM_PROGS = DEF_NUM_PROGS,
  parameter int CPI       = DEF_CPI
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         start,
  input  logic [$clog2(NUM_PROGS)-1:0] prog_sel,
  input  logic                         branch_en,
  input  logic                         branch_taken,
  input  logic [$clog2(LUT_DEPTH)-1:0] target,
  input  logic                         lut_we,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
  input  logic [OFFSET_W:0]            lut_wdata,
  input  logic                         prog_we,
  input  logic [$clog2(NUM_PROGS)-1:0] prog_waddr,
  input  logic [PC_W-1:0]              prog_wstart,
  input  logic [PC_W-1:0]              prog_wend,
`ifdef PC_SEQUENCER_BRANCH_ABS_EN
  input  logic                         branch_abs,
  input  logic [PC_W-1:0]              abs_target,
`endif
  output logic [PC_W-1:0]              pc,
  output logic [$clog2(CPI)-1:0]       phase,
  output logic                         busy,
  output logic                         halt,
  output logic                         fault
);

  localparam int PS_W = $clog2(NUM_PROGS);
  localparam int PH_W = $clog2(CPI);
  localparam int EW   = ((PC_W > OFFSET_W) ? PC_W : OFFSET_W) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CPI - 1);
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_HALT = 2'(HALT);

  logic [1:0]      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PH_W-1:0] phase_reg, phase_next;
  logic [PS_W-1:0] slot_reg, slot_next;
  logic            fault_reg, fault_next;
  logic [PC_W-1:0] prog_start_reg [NUM_PROGS];
  logic [PC_W-1:0] prog_end_reg   [NUM_PROGS];

  logic [OFFSET_W:0] lut_rdata;
  logic [EW-1:0]     rel_sum, inc_sum;
  logic              abs_hit;
  logic [PC_W-1:0]   abs_pc;

`ifdef PC_SEQUENCER_BRANCH_ABS_EN
  assign abs_hit = branch_abs && branch_taken;
  assign abs_pc  = abs_target;
`else
  assign abs_hit = 1'b0;
  assign abs_pc  = '0;
`endif

  branch_lut #(.DEPTH(LUT_DEPTH), .DW(OFFSET_W + 1)) u_lut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (target),
    .rdata (lut_rdata)
  );

  for (genvar gi = 0; gi < NUM_PROGS; gi++) begin : g_slot
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        prog_start_reg[gi] <= '0;
        prog_end_reg[gi]   <= '0;
      end else if (prog_we && prog_waddr == PS_W'(gi)) begin
        prog_start_reg[gi] <= prog_wstart;
        prog_end_reg[gi]   <= prog_wend;
      end
    end
  end

  // Widened arithmetic: any bit above PC_W-1 is a carry or borrow out.
  assign rel_sum = lut_rdata[OFFSET_W] ? (EW'(pc_reg) - EW'(lut_rdata[OFFSET_W-1:0]))
                                       : (EW'(pc_reg) + EW'(lut_rdata[OFFSET_W-1:0]));
  assign inc_sum = EW'(pc_reg) + EW'(1);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    phase_next = phase_reg;
    slot_next  = slot_reg;
    fault_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        phase_next = '0;
        if (start) begin
          if ({1'b0, prog_sel} < (PS_W + 1)'(NUM_PROGS)) begin
            pc_next    = prog_start_reg[prog_sel];
            slot_next  = prog_sel;
            state_next = ST_RUN;
          end else begin
            fault_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (phase_reg == PH_LAST) begin
          phase_next = '0;
          if (pc_reg == prog_end_reg[slot_reg]) begin
            state_next = ST_HALT;
          end else if (abs_hit) begin
            pc_next = abs_pc;
          end else if (branch_en && branch_taken) begin
            pc_next    = rel_sum[PC_W-1:0];
            fault_next = |rel_sum[EW-1:PC_W];
          end else begin
            pc_next    = inc_sum[PC_W-1:0];
            fault_next = |inc_sum[EW-1:PC_W];
          end
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end
      ST_HALT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      phase_reg <= '0;
      slot_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      phase_reg <= phase_next;
      slot_reg  <= slot_next;
      fault_reg <= fault_next;
    end
  end

  assign pc    = pc_reg;
  assign phase = phase_reg;
  assign busy  = (state_reg == ST_RUN);
  assign halt  = (state_reg == ST_HALT);
  assign fault = fault_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of single-commit branch vectors plus
// hand-written sequences for run/halt, phase gating, LUT hazards and reset.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        CLK, RST_N, start, branch_en, branch_taken, lut_we, prog_we;
  logic [1:0]  prog_sel, prog_waddr;
  logic [4:0]  target, lut_waddr;
  logic [9:0]  lut_wdata;
  logic [11:0] prog_wstart, prog_wend, pc;
  logic [1:0]  phase;
  logic        busy, halt, fault;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .prog_sel(prog_sel),
    .branch_en(branch_en), .branch_taken(branch_taken), .target(target),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wstart(prog_wstart),
    .prog_wend(prog_wend), .pc(pc), .phase(phase), .busy(busy), .halt(halt),
    .fault(fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] s;
    logic        dir;
    logic [8:0]  mag;
    logic [4:0]  idx;
    logic        en;
    logic        tk;
    logic [11:0] exp_pc;
    logic        exp_f;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic write_lut(input logic [4:0] idx, input logic d, input logic [8:0] m);
    br_off_t bw;
    bw.dir = d;
    bw.mag = m;
    lut_we = 1'b1; lut_waddr = idx; lut_wdata = bw;
    @(negedge CLK);
    lut_we = 1'b0;
  endtask

  task automatic write_prog(input logic [1:0] slot, input logic [11:0] s, input logic [11:0] e);
    prog_we = 1'b1; prog_waddr = slot; prog_wstart = s; prog_wend = e;
    @(negedge CLK);
    prog_we = 1'b0;
  endtask

  task automatic launch(input logic [1:0] sel);
    start = 1'b1; prog_sel = sel;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic wait_phase3();
    int n = 0;
    while (phase != 2'd3 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_phase3", phase, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; start = 0; prog_sel = 0; branch_en = 0; branch_taken = 0;
    target = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0; prog_we = 0;
    prog_waddr = 0; prog_wstart = 0; prog_wend = 0;

    //                s       dir   mag     idx   en    tk    exp_pc   f
    vecs[0] = '{12'd20,   1'b1, 9'd3,   5'd0,  1'b1, 1'b1, 12'd17,   1'b0};
    vecs[1] = '{12'd4090, 1'b0, 9'd10,  5'd5,  1'b1, 1'b1, 12'd4,    1'b1};
    vecs[2] = '{12'd30,   1'b0, 9'd3,   5'd3,  1'b1, 1'b0, 12'd31,   1'b0};
    vecs[3] = '{12'd30,   1'b0, 9'd3,   5'd3,  1'b0, 1'b1, 12'd31,   1'b0};
    vecs[4] = '{12'd4095, 1'b0, 9'd1,   5'd1,  1'b0, 1'b0, 12'd0,    1'b1};
    vecs[5] = '{12'd2,    1'b1, 9'd5,   5'd9,  1'b1, 1'b1, 12'd4093, 1'b1};
    vecs[6] = '{12'd100,  1'b0, 9'd511, 5'd31, 1'b1, 1'b1, 12'd611,  1'b0};
    vecs[7] = '{12'd511,  1'b1, 9'd511, 5'd16, 1'b1, 1'b1, 12'd0,    1'b0};

    // Reset state, held and after release
    repeat (2) @(negedge CLK);
    chk("rst_pc", pc, 0); chk("rst_phase", phase, 0); chk("rst_busy", busy, 0);
    chk("rst_halt", halt, 0); chk("rst_fault", fault, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_busy", busy, 0); chk("idle_pc", pc, 0);

    // Single-commit vectors
    for (int v = 0; v < 8; v++) begin
      do_reset();
      write_lut(vecs[v].idx, vecs[v].dir, vecs[v].mag);
      write_prog(2'd0, vecs[v].s, vecs[v].s ^ 12'h555);
      launch(2'd0);
      chk($sformatf("vec%0d_start_pc", v), pc, vecs[v].s);
      wait_phase3();
      branch_en = vecs[v].en; branch_taken = vecs[v].tk; target = vecs[v].idx;
      @(negedge CLK);
      branch_en = 0; branch_taken = 0; target = 0;
      chk($sformatf("vec%0d_pc", v), pc, vecs[v].exp_pc);
      chk($sformatf("vec%0d_fault", v), fault, vecs[v].exp_f);
      chk($sformatf("vec%0d_phase", v), phase, 0);
      chk($sformatf("vec%0d_busy", v), busy, 1);
      @(negedge CLK);
      chk($sformatf("vec%0d_fault_clear", v), fault, 0);
    end

    // Straight-line run 10..13, start while busy ignored, halt pulse
    do_reset();
    write_prog(2'd0, 12'd10, 12'd13);
    write_prog(2'd1, 12'd200, 12'd200);
    launch(2'd0);
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) begin
        chk("run_pc", pc, 10 + k);
        chk("run_phase", phase, p);
        chk("run_busy", busy, 1);
        chk("run_halt", halt, 0);
        start = (k == 1 && p == 1); prog_sel = 2'd1;
        @(negedge CLK);
        start = 1'b0;
      end
    end
    chk("halt_pulse", halt, 1); chk("halt_busy", busy, 0); chk("halt_pc", pc, 13);
    @(negedge CLK);
    chk("after_halt", halt, 0); chk("after_halt_busy", busy, 0);

    // Bad slot select in IDLE
    launch(2'd3);
    chk("badsel_fault", fault, 1); chk("badsel_pc", pc, 13); chk("badsel_busy", busy, 0);
    @(negedge CLK);
    chk("badsel_fault_clear", fault, 0);

    // Branch asserted on phase 1 is ignored; on phase 3 it is taken
    do_reset();
    write_lut(5'd0, 1'b1, 9'd3);
    write_prog(2'd0, 12'd20, 12'd40);
    launch(2'd0);
    @(negedge CLK);
    branch_en = 1; branch_taken = 1; target = 5'd0;
    @(negedge CLK);
    branch_en = 0; branch_taken = 0;
    @(negedge CLK);
    chk("gate_phase", phase, 3);
    @(negedge CLK);
    chk("phase1_branch_ignored", pc, 21);
    repeat (3) @(negedge CLK);
    chk("gate_phase_b", phase, 3);
    branch_en = 1; branch_taken = 1; target = 5'd0;
    @(negedge CLK);
    branch_en = 0; branch_taken = 0;
    chk("phase3_branch", pc, 18);

    // LUT write/read hazard at index 7, then live end-address update
    do_reset();
    write_lut(5'd7, 1'b0, 9'd5);
    write_prog(2'd0, 12'd50, 12'd90);
    launch(2'd0);
    repeat (3) @(negedge CLK);
    chk("hz_phase", phase, 3);
    branch_en = 1; branch_taken = 1; target = 5'd7;
    lut_we = 1; lut_waddr = 5'd7; lut_wdata = {1'b0, 9'd20};
    @(negedge CLK);
    branch_en = 0; branch_taken = 0; lut_we = 0;
    chk("hz_old_offset", pc, 55);
    @(negedge CLK);
    write_prog(2'd0, 12'd50, 12'd75);
    @(negedge CLK);
    chk("hz_phase_b", phase, 3);
    branch_en = 1; branch_taken = 1; target = 5'd7;
    @(negedge CLK);
    branch_en = 0; branch_taken = 0;
    chk("hz_new_offset", pc, 75);
    repeat (4) @(negedge CLK);
    chk("live_end_halt", halt, 1); chk("live_end_pc", pc, 75);
    @(negedge CLK);

    // Reset mid-run aborts without a halt pulse
    launch(2'd0);
    repeat (2) @(negedge CLK);
    chk("abort_phase", phase, 2);
    RST_N = 1'b0;
    #1;
    chk("abort_pc", pc, 0); chk("abort_busy", busy, 0);
    chk("abort_halt", halt, 0); chk("abort_phase0", phase, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("post_abort_halt", halt, 0);
      chk("post_abort_busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
